control_unit: RTL and testbench

Hardwired control sequencer for the RISC CPU. It sits directly upstream of `DataPath` and drives every DataPath control input from the fetched instruction register, replacing hand-written per-instruction stimulus. It is a Moore FSM with one state per T-step, covering fetch, decode and execute for all implemented opcodes, including halt.

---
 rtl/control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the RISC DataPath: one state per T-step,
// state and control word advance on the falling clock edge.
module control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        IncPC,
  output logic        ZLOout,
  output logic        ZLOin,
  output logic        Cout,
  output logic        MDRout,
  output logic        RAMenable,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        read,
  output logic        write,
  output logic        conin,
  output logic        Yin,
  output logic        R15in,
  output logic        ZMuxEnable,
  output logic        ZSelect,
  output logic        ZMuxOut,
  output logic        OutPortenable,
  output logic        PortInout,
  output logic [4:0]  aluControl,
  output logic        run
);

  typedef enum logic [4:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU_R, C_ALU_I, C_LDI, C_LD, C_ST, C_BR, C_JR, C_JAL, C_IN, C_OUT, C_HALT
  } cls_t;

  typedef struct packed {
    logic       pc_out, inc_pc, zlo_in, c_out, mdr_out, ram_enable, mar_in, pc_in;
    logic       mdr_in, ir_in, gra, grb, grc, rin, rout, ba_out, read, write;
    logic       con_in, yin, r15_in, zmux, out_port_enable, port_inout, br_t6, run;
    logic [4:0] alu;
  } ctl_t;

  state_t state, state_nxt;
  cls_t   cls, cls_nxt;
  logic [4:0] op, op_nxt;
  ctl_t   ctl;

  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  function automatic cls_t cls_of(input logic [4:0] o);
    case (o)
      5'b00000: cls_of = C_LD;
      5'b00001: cls_of = C_LDI;
      5'b00010: cls_of = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: cls_of = C_ALU_R;
      5'b01100, 5'b01101, 5'b01110: cls_of = C_ALU_I;
      5'b10010: cls_of = C_BR;
      5'b10011: cls_of = C_JR;
      5'b10100: cls_of = C_JAL;
      5'b10101: cls_of = C_IN;
      5'b10110: cls_of = C_OUT;
      5'b11011: cls_of = C_HALT;
      default:  cls_of = C_NOP;
    endcase
  endfunction

  // Control word for the state being entered; registering it keeps outputs glitch-free.
  function automatic ctl_t ctl_of(input state_t s, input cls_t c, input logic [4:0] o);
    ctl_t k;
    k = '0;
    k.run = (s != S_RESET) && (s != S_HALT);
    case (s)
      S_T0: begin k.pc_out = 1'b1; k.mar_in = 1'b1; k.inc_pc = 1'b1; end
      S_T1: begin k.read = 1'b1; k.ram_enable = 1'b1; k.mdr_in = 1'b1; end
      S_T2: begin k.mdr_out = 1'b1; k.ir_in = 1'b1; end
      S_T3: case (c)
        C_ALU_R, C_ALU_I: begin k.grb = 1'b1; k.rout = 1'b1; k.yin = 1'b1; end
        C_LDI, C_LD, C_ST: begin k.grb = 1'b1; k.rout = 1'b1; k.ba_out = 1'b1; k.yin = 1'b1; end
        C_BR:  begin k.gra = 1'b1; k.rout = 1'b1; k.con_in = 1'b1; end
        C_JR:  begin k.gra = 1'b1; k.rout = 1'b1; k.pc_in = 1'b1; end
        C_JAL: begin k.pc_out = 1'b1; k.r15_in = 1'b1; end
        C_IN:  begin k.port_inout = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        C_OUT: begin k.gra = 1'b1; k.rout = 1'b1; k.out_port_enable = 1'b1; end
        default: ;
      endcase
      S_T4: case (c)
        C_ALU_R: begin k.grc = 1'b1; k.rout = 1'b1; k.zlo_in = 1'b1; k.alu = o; end
        C_ALU_I: begin
          k.c_out = 1'b1; k.zlo_in = 1'b1;
          k.alu = (o == 5'b01100) ? 5'b00011 : (o == 5'b01101) ? 5'b00101 : 5'b00110;
        end
        C_LDI, C_LD, C_ST: begin k.c_out = 1'b1; k.zlo_in = 1'b1; k.alu = ADD_OP; end
        C_BR:  begin k.pc_out = 1'b1; k.yin = 1'b1; end
        C_JAL: begin k.gra = 1'b1; k.rout = 1'b1; k.pc_in = 1'b1; end
        default: ;
      endcase
      S_T5: case (c)
        C_ALU_R, C_ALU_I, C_LDI: begin k.zmux = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        C_LD, C_ST: begin k.zmux = 1'b1; k.mar_in = 1'b1; end
        C_BR: begin k.c_out = 1'b1; k.zlo_in = 1'b1; k.alu = ADD_OP; end
        default: ;
      endcase
      S_T6: case (c)
        C_LD: begin k.read = 1'b1; k.ram_enable = 1'b1; k.mdr_in = 1'b1; end
        C_ST: begin k.gra = 1'b1; k.rout = 1'b1; k.mdr_in = 1'b1; end
        C_BR: k.br_t6 = 1'b1;
        default: ;
      endcase
      S_T7: case (c)
        C_LD: begin k.mdr_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
        C_ST: begin k.write = 1'b1; k.ram_enable = 1'b1; end
        default: ;
      endcase
      default: ;
    endcase
    return k;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_nxt = state;
    cls_nxt   = cls;
    op_nxt    = op;
    unique case (state)
      S_RESET: state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2: begin
        op_nxt    = IR[31:27];
        cls_nxt   = cls_of(IR[31:27]);
        state_nxt = (cls_nxt == C_HALT) ? S_HALT : S_T3;
      end
      S_T3:    state_nxt = (cls inside {C_JR, C_IN, C_OUT, C_NOP}) ? S_T0 : S_T4;
      S_T4:    state_nxt = (cls == C_JAL) ? S_T0 : S_T5;
      S_T5:    state_nxt = (cls inside {C_ALU_R, C_ALU_I, C_LDI}) ? S_T0 : S_T6;
      S_T6:    state_nxt = (cls == C_BR) ? S_T0 : S_T7;
      S_T7:    state_nxt = S_T0;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  // NOTE: state and control word use non-blocking assignments on the falling edge,
  // and clear resets them asynchronously so outputs drop without waiting for a clock.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RESET;
      cls   <= C_NOP;
      op    <= '0;
      ctl   <= '0;
    end else begin
      state <= state_nxt;
      cls   <= cls_nxt;
      op    <= op_nxt;
      ctl   <= ctl_of(state_nxt, cls_nxt, op_nxt);
    end
  end

  assign PCout         = ctl.pc_out;
  assign IncPC         = ctl.inc_pc;
  assign ZLOout        = 1'b0;
  assign ZLOin         = ctl.zlo_in;
  assign Cout          = ctl.c_out;
  assign MDRout        = ctl.mdr_out;
  assign RAMenable     = ctl.ram_enable;
  assign MARin         = ctl.mar_in;
  assign MDRin         = ctl.mdr_in;
  assign IRin          = ctl.ir_in;
  assign Gra           = ctl.gra;
  assign Grb           = ctl.grb;
  assign Grc           = ctl.grc;
  assign Rin           = ctl.rin;
  assign Rout          = ctl.rout;
  assign BAout         = ctl.ba_out;
  assign read          = ctl.read;
  assign write         = ctl.write;
  assign conin         = ctl.con_in;
  assign Yin           = ctl.yin;
  assign R15in         = ctl.r15_in;
  assign ZSelect       = 1'b0;
  assign OutPortenable = ctl.out_port_enable;
  assign PortInout     = ctl.port_inout;
  assign aluControl    = ctl.alu;
  assign run           = ctl.run;
  // The branch-taken controls in T6 follow CON_FF combinationally.
  assign PCin          = ctl.pc_in | (ctl.br_t6 & CON_FF);
  assign ZMuxEnable    = ctl.zmux  | (ctl.br_t6 & CON_FF);
  assign ZMuxOut       = ctl.zmux  | (ctl.br_t6 & CON_FF);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table vectors, corner sequences and random
// instructions compared cycle by cycle against a per-instruction step-list model.
module tb_control_unit;

  typedef logic [32:0] cw_t;

  localparam cw_t PCOUT  = cw_t'(1) << 32;
  localparam cw_t INCPC  = cw_t'(1) << 31;
  localparam cw_t ZLOIN  = cw_t'(1) << 29;
  localparam cw_t COUT   = cw_t'(1) << 28;
  localparam cw_t MDROUT = cw_t'(1) << 27;
  localparam cw_t RAME   = cw_t'(1) << 26;
  localparam cw_t MARIN  = cw_t'(1) << 25;
  localparam cw_t PCIN   = cw_t'(1) << 24;
  localparam cw_t MDRIN  = cw_t'(1) << 23;
  localparam cw_t IRIN   = cw_t'(1) << 22;
  localparam cw_t GRA    = cw_t'(1) << 21;
  localparam cw_t GRB    = cw_t'(1) << 20;
  localparam cw_t GRC    = cw_t'(1) << 19;
  localparam cw_t RIN    = cw_t'(1) << 18;
  localparam cw_t ROUT   = cw_t'(1) << 17;
  localparam cw_t BAOUT  = cw_t'(1) << 16;
  localparam cw_t READ   = cw_t'(1) << 15;
  localparam cw_t WRITE  = cw_t'(1) << 14;
  localparam cw_t CONIN  = cw_t'(1) << 13;
  localparam cw_t YIN    = cw_t'(1) << 12;
  localparam cw_t R15IN  = cw_t'(1) << 11;
  localparam cw_t ZOUT   = (cw_t'(1) << 10) | (cw_t'(1) << 8);
  localparam cw_t OUTPE  = cw_t'(1) << 7;
  localparam cw_t PORTIO = cw_t'(1) << 6;
  localparam cw_t RUN    = cw_t'(1) << 5;
  localparam cw_t T0W    = RUN | PCOUT | MARIN | INCPC;

  typedef struct {
    logic [31:0] ir;
    logic        con;
    int          len;
    cw_t         last;
  } vec_t;

  logic clock = 1'b0;
  logic clear;
  logic [31:0] IR;
  logic CON_FF;
  logic PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin, IRin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, read, write, conin, Yin, R15in;
  logic ZMuxEnable, ZSelect, ZMuxOut, OutPortenable, PortInout, run;
  logic [4:0] aluControl;

  int checks = 0;
  int errors = 0;
  cw_t exp_q[$];
  vec_t tbl[15];

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .ZLOin(ZLOin), .Cout(Cout),
    .MDRout(MDRout), .RAMenable(RAMenable), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .read(read), .write(write), .conin(conin), .Yin(Yin), .R15in(R15in),
    .ZMuxEnable(ZMuxEnable), .ZSelect(ZSelect), .ZMuxOut(ZMuxOut),
    .OutPortenable(OutPortenable), .PortInout(PortInout), .aluControl(aluControl), .run(run)
  );

  always #5 clock = ~clock;

  cw_t obs;
  assign obs = {PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin,
                IRin, Gra, Grb, Grc, Rin, Rout, BAout, read, write, conin, Yin, R15in,
                ZMuxEnable, ZSelect, ZMuxOut, OutPortenable, PortInout, run, aluControl};

  task automatic check(input string name, input cw_t got, input cw_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Expected control words per cycle for one instruction, listed step by step.
  task automatic build_exp(input logic [4:0] op, input logic con);
    int o;
    o = int'(op);
    exp_q.delete();
    exp_q.push_back(T0W);
    exp_q.push_back(RUN | READ | RAME | MDRIN);
    exp_q.push_back(RUN | MDROUT | IRIN);
    if (o >= 3 && o <= 11) begin
      exp_q.push_back(RUN | GRB | ROUT | YIN);
      exp_q.push_back(RUN | GRC | ROUT | ZLOIN | cw_t'(op));
      exp_q.push_back(RUN | ZOUT | GRA | RIN);
    end else if (o >= 12 && o <= 14) begin
      exp_q.push_back(RUN | GRB | ROUT | YIN);
      exp_q.push_back(RUN | COUT | ZLOIN | cw_t'(o == 12 ? 3 : (o == 13 ? 5 : 6)));
      exp_q.push_back(RUN | ZOUT | GRA | RIN);
    end else if (o <= 2) begin
      exp_q.push_back(RUN | GRB | ROUT | BAOUT | YIN);
      exp_q.push_back(RUN | COUT | ZLOIN | cw_t'(3));
      if (o == 1) exp_q.push_back(RUN | ZOUT | GRA | RIN);
      else begin
        exp_q.push_back(RUN | ZOUT | MARIN);
        if (o == 0) begin
          exp_q.push_back(RUN | READ | RAME | MDRIN);
          exp_q.push_back(RUN | MDROUT | GRA | RIN);
        end else begin
          exp_q.push_back(RUN | GRA | ROUT | MDRIN);
          exp_q.push_back(RUN | WRITE | RAME);
        end
      end
    end else if (o == 18) begin
      exp_q.push_back(RUN | GRA | ROUT | CONIN);
      exp_q.push_back(RUN | PCOUT | YIN);
      exp_q.push_back(RUN | COUT | ZLOIN | cw_t'(3));
      exp_q.push_back(con ? (RUN | ZOUT | PCIN) : RUN);
    end else if (o == 19) exp_q.push_back(RUN | GRA | ROUT | PCIN);
    else if (o == 20) begin
      exp_q.push_back(RUN | PCOUT | R15IN);
      exp_q.push_back(RUN | GRA | ROUT | PCIN);
    end else if (o == 21) exp_q.push_back(RUN | PORTIO | GRA | RIN);
    else if (o == 22) exp_q.push_back(RUN | GRA | ROUT | OUTPE);
    else if (o != 27) exp_q.push_back(RUN);
  endtask

  // Runs len cycles from T0; cycles past the model's list are expected to be T0 again.
  task automatic run_instr(input string name, input logic [31:0] ir, input logic con,
                           input int len, output cw_t last);
    IR = ir;
    CON_FF = con;
    last = '0;
    for (int i = 0; i < len; i++) begin
      @(posedge clock); #1;
      check($sformatf("%s_t%0d", name, i), obs, (i < exp_q.size()) ? exp_q[i] : T0W);
      last = obs;
    end
  endtask

  initial begin
    cw_t last;
    logic [4:0] rop;
    logic rcon;

    tbl[0]  = '{32'h71A00025, 1'b0, 6, RUN | ZOUT | GRA | RIN};
    tbl[1]  = '{32'h10800010, 1'b0, 8, RUN | WRITE | RAME};
    tbl[2]  = '{32'h18000000, 1'b0, 6, RUN | ZOUT | GRA | RIN};
    tbl[3]  = '{32'h08000000, 1'b0, 6, RUN | ZOUT | GRA | RIN};
    tbl[4]  = '{32'h00000000, 1'b0, 8, RUN | MDROUT | GRA | RIN};
    tbl[5]  = '{32'h90000000, 1'b0, 7, RUN};
    tbl[6]  = '{32'h90000000, 1'b1, 7, RUN | ZOUT | PCIN};
    tbl[7]  = '{32'h98000000, 1'b0, 4, RUN | GRA | ROUT | PCIN};
    tbl[8]  = '{32'hA0000000, 1'b0, 5, RUN | GRA | ROUT | PCIN};
    tbl[9]  = '{32'hA8000000, 1'b0, 4, RUN | PORTIO | GRA | RIN};
    tbl[10] = '{32'hB0000000, 1'b0, 4, RUN | GRA | ROUT | OUTPE};
    tbl[11] = '{32'hD0000000, 1'b0, 4, RUN};
    tbl[12] = '{32'hF8000000, 1'b1, 4, RUN};
    tbl[13] = '{32'h50000000, 1'b0, 6, RUN | ZOUT | GRA | RIN};
    tbl[14] = '{32'h68000000, 1'b0, 6, RUN | ZOUT | GRA | RIN};

    clear = 1'b0;
    IR = 32'hFFFFFFFF;
    CON_FF = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("reset", obs, '0);
    end
    clear = 1'b1;

    foreach (tbl[i]) begin
      build_exp(tbl[i].ir[31:27], tbl[i].con);
      run_instr($sformatf("vec%0d", i), tbl[i].ir, tbl[i].con, tbl[i].len, last);
      check($sformatf("vec%0d_last", i), last, tbl[i].last);
    end

    // halt: fetch only, then controls stay low until clear is pulsed
    build_exp(5'b11011, 1'b0);
    run_instr("halt", 32'hD8000000, 1'b0, 3, last);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      check("halt_hold", obs, '0);
    end
    clear = 1'b0;
    #2;
    check("halt_clear", obs, '0);
    clear = 1'b1;
    build_exp(5'b11010, 1'b0);
    run_instr("after_halt", 32'hD0000000, 1'b0, 4, last);

    // ld interrupted asynchronously during T6
    build_exp(5'b00000, 1'b0);
    run_instr("ld_cut", 32'h00000000, 1'b0, 7, last);
    clear = 1'b0;
    #1;
    check("async_clear", obs, '0);
    @(posedge clock); #1;
    check("async_hold", obs, '0);
    clear = 1'b1;
    build_exp(5'b00001, 1'b0);
    run_instr("after_cut", 32'h08000000, 1'b0, 6, last);

    for (int n = 0; n < 40; n++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'b11011) rop = 5'b11010;
      rcon = 1'($urandom_range(0, 1));
      build_exp(rop, rcon);
      run_instr($sformatf("rand%0d_op%0d", n, rop), {rop, 27'($urandom)}, rcon,
                exp_q.size(), last);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
